// File: rtl/otp_passcode_sequencer.sv
`timescale 1ns/1ps
// otp_passcode_sequencer
//   Command-level controller for OTP access via an I2C byte-write engine.
//   A host start runs seven single-byte writes to DEV_ADDR: the six passcode
//   bytes to PASS_REG, then the latched OTP command to OTP_REG. Between writes
//   it keeps an idle gap. NACKed bytes are retried, and a stuck engine is cut
//   off by a timeout. The result is reported as a done or error pulse.
//
//   Optional macro OTP_CMD_CHECK_EN: when defined, a start with an OTP command
//   outside {00,11,01} fails at once with err_code=3 and err_index=6, and no
//   engine request is issued. When undefined, any command byte is forwarded.
//
// Ports
//   clk_sda, rst_n      clock, async active-low reset
//   start, otp_cmd      host request pulse and command byte (sampled in IDLE)
//   busy, done, error   status; done/error are single-cycle pulses
//   err_code/err_index  failure cause and failing byte, held until next start
//   eng_req/eng_ack     request handshake to the byte engine
//   eng_dev_addr, eng_reg_addr, eng_data   write fields, valid while eng_req
//   eng_done/eng_nack   engine completion pulse and NACK qualifier
module otp_passcode_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h0A,
  parameter logic [7:0]  PASS_REG   = 8'h05,
  parameter logic [7:0]  OTP_REG    = 8'h04,
  parameter logic [47:0] PASSCODE   = 48'h50_48_53_47_4E_58,
  parameter int          GAP_CYCLES = 10,
  parameter int          MAX_RETRY  = 2,
  parameter int          TIMEOUT    = 255
) (
  input  logic       clk_sda,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] otp_cmd,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [2:0] err_index,
  output logic       eng_req,
  output logic [6:0] eng_dev_addr,
  output logic [7:0] eng_reg_addr,
  output logic [7:0] eng_data,
  input  logic       eng_ack,
  input  logic       eng_done,
  input  logic       eng_nack
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_GAP, S_DONE, S_ERROR} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cmd;
  logic [2:0]  r_index;
  logic [2:0]  r_retry;
  logic [7:0]  r_cnt;      // shared: timeout count in S_WAIT, gap count in S_GAP
  logic [1:0]  r_err_code;
  logic [2:0]  r_err_index;
  logic [7:0]  w_pass_byte;
  logic        w_last, w_retry_ok, w_tmo, w_gap_end, w_cmd_bad;

  assign w_last     = (r_index == 3'd6);
  assign w_retry_ok = (r_retry < 3'(MAX_RETRY));
  // The count is 0 in the first wait/gap cycle, so the last permitted cycle
  // is the one that holds N-1.
  assign w_tmo      = (r_cnt >= 8'(TIMEOUT - 1));
  assign w_gap_end  = (r_cnt >= 8'(GAP_CYCLES - 1));

`ifdef OTP_CMD_CHECK_EN
  assign w_cmd_bad = !(otp_cmd inside {8'h00, 8'h11, 8'h01});
`else
  assign w_cmd_bad = 1'b0;
`endif

  assign err_code  = r_err_code;
  assign err_index = r_err_index;

  // The passcode is sent MSB byte first.
  always_comb begin
    w_pass_byte = 8'h00;
    case (r_index)
      3'd0:    w_pass_byte = PASSCODE[47:40];
      3'd1:    w_pass_byte = PASSCODE[39:32];
      3'd2:    w_pass_byte = PASSCODE[31:24];
      3'd3:    w_pass_byte = PASSCODE[23:16];
      3'd4:    w_pass_byte = PASSCODE[15:8];
      3'd5:    w_pass_byte = PASSCODE[7:0];
      default: w_pass_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sda or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    eng_req      = 1'b0;
    eng_dev_addr = '0;
    eng_reg_addr = '0;
    eng_data     = '0;
    case (r_state)
      S_IDLE: if (start) w_next = w_cmd_bad ? S_ERROR : S_REQ;
      S_REQ: begin
        busy         = 1'b1;
        eng_req      = 1'b1;
        eng_dev_addr = DEV_ADDR;
        eng_reg_addr = w_last ? OTP_REG : PASS_REG;
        eng_data     = w_last ? r_cmd : w_pass_byte;
        if (eng_ack) w_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // A completion on the expiry cycle still counts as completion.
        if (eng_done) begin
          if (!eng_nack)       w_next = w_last ? S_DONE : S_GAP;
          else if (w_retry_ok) w_next = S_GAP;
          else                 w_next = S_ERROR;
        end else if (w_tmo) begin
          w_next = S_ERROR;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (w_gap_end) w_next = S_REQ;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERROR: begin
        error  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sda or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_index     <= '0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_err_code  <= '0;
      r_err_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_cmd       <= otp_cmd;
          r_index     <= '0;
          r_retry     <= '0;
          r_cnt       <= '0;
          r_err_code  <= w_cmd_bad ? 2'd3 : 2'd0;
          r_err_index <= w_cmd_bad ? 3'd6 : 3'd0;
        end
        S_REQ: if (eng_ack) r_cnt <= '0;
        S_WAIT: begin
          if (eng_done) begin
            r_cnt <= '0;
            if (!eng_nack) begin
              // Index only moves after a good byte, and stops at the last one.
              if (!w_last) begin
                r_index <= r_index + 3'd1;
                r_retry <= '0;
              end
            end else if (w_retry_ok) begin
              r_retry <= r_retry + 3'd1;
            end else begin
              r_err_code  <= 2'd1;
              r_err_index <= r_index;
            end
          end else if (w_tmo) begin
            r_err_code  <= 2'd2;
            r_err_index <= r_index;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_GAP: if (!w_gap_end) r_cnt <= r_cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_passcode_sequencer.sv
`timescale 1ns/1ps
module tb_otp_passcode_sequencer;
  localparam int GAP  = 10;
  localparam int MAXR = 2;
  localparam int TMO  = 255;

  logic       clk_sda = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] otp_cmd = 8'h00;
  logic       busy, done, error, eng_req;
  logic [1:0] err_code;
  logic [2:0] err_index;
  logic [6:0] eng_dev_addr;
  logic [7:0] eng_reg_addr, eng_data;
  logic       eng_ack = 1'b0, eng_done = 1'b0, eng_nack = 1'b0;

  otp_passcode_sequencer dut (
    .clk_sda(clk_sda), .rst_n(rst_n), .start(start), .otp_cmd(otp_cmd),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
    .eng_req(eng_req), .eng_dev_addr(eng_dev_addr), .eng_reg_addr(eng_reg_addr),
    .eng_data(eng_data), .eng_ack(eng_ack), .eng_done(eng_done), .eng_nack(eng_nack)
  );

  always #5 clk_sda = ~clk_sda;

  int cyc = 0;
  always @(posedge clk_sda) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (event-time based) ----------------
  logic [7:0] PASS_B [0:5] = '{8'h50, 8'h48, 8'h53, 8'h47, 8'h4E, 8'h58};

  function automatic bit cmd_illegal(input logic [7:0] c);
`ifdef OTP_CMD_CHECK_EN
    return !(c == 8'h00 || c == 8'h11 || c == 8'h01);
`else
    return 1'b0;
`endif
  endfunction

  bit         m_active = 0, m_wait = 0, e_req;
  int         m_req_from = 0, m_hs = 0, m_idx = 0, m_tries = 0;
  int         m_pulse_cyc = -1, m_kind = 0, m_code = 0, m_eidx = 0;
  logic [7:0] m_cmd = 8'h00;

  // monitor records
  logic [15:0] q_wr [$];
  int          hs_cyc = 0, done_cyc = 0, err_cyc = 0, n_pulse = 0, n_done = 0;

  always @(negedge clk_sda) begin
    if (!rst_n) begin
      m_active = 0; m_wait = 0; m_pulse_cyc = -1; m_kind = 0; m_code = 0; m_eidx = 0;
      chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
      chk("rst_error", error, 0);         chk("rst_eng_req", eng_req, 0);
      chk("rst_err_code", err_code, 0);   chk("rst_err_index", err_index, 0);
      chk("rst_dev", eng_dev_addr, 0);    chk("rst_reg", eng_reg_addr, 0);
      chk("rst_data", eng_data, 0);
    end else begin
      e_req = m_active && !m_wait && (cyc >= m_req_from);
      chk("busy", busy, m_active);
      chk("done", done, (m_pulse_cyc == cyc && m_kind == 1));
      chk("error", error, (m_pulse_cyc == cyc && m_kind == 2));
      chk("err_code", err_code, m_code);
      chk("err_index", err_index, m_eidx);
      chk("eng_req", eng_req, e_req);
      if (e_req) begin
        chk("dev_addr", eng_dev_addr, 7'h0A);
        chk("reg_addr", eng_reg_addr, (m_idx < 6) ? 8'h05 : 8'h04);
        chk("data", eng_data, (m_idx < 6) ? PASS_B[m_idx] : m_cmd);
      end
      if (eng_req && eng_ack) begin q_wr.push_back({eng_reg_addr, eng_data}); hs_cyc = cyc; end
      if (done)  begin n_pulse++; n_done++; done_cyc = cyc; end
      if (error) begin n_pulse++; err_cyc = cyc; end
      // advance the model with this cycle's inputs
      if (!m_active && m_pulse_cyc != cyc) begin
        if (start) begin
          m_cmd = otp_cmd; m_idx = 0; m_tries = 0; m_code = 0; m_eidx = 0;
          if (cmd_illegal(otp_cmd)) begin
            m_pulse_cyc = cyc + 1; m_kind = 2; m_code = 3; m_eidx = 6;
          end else begin
            m_active = 1; m_wait = 0; m_req_from = cyc + 1;
          end
        end
      end else if (m_active) begin
        if (!m_wait) begin
          if (e_req && eng_ack) begin m_wait = 1; m_hs = cyc; end
        end else if (eng_done) begin
          m_wait = 0;
          if (!eng_nack) begin
            if (m_idx == 6) begin m_active = 0; m_pulse_cyc = cyc + 1; m_kind = 1; end
            else begin m_idx++; m_tries = 0; m_req_from = cyc + 1 + GAP; end
          end else if (m_tries < MAXR) begin
            m_tries++; m_req_from = cyc + 1 + GAP;
          end else begin
            m_active = 0; m_pulse_cyc = cyc + 1; m_kind = 2; m_code = 1; m_eidx = m_idx;
          end
        end else if (cyc - m_hs >= TMO) begin
          m_active = 0; m_pulse_cyc = cyc + 1; m_kind = 2; m_code = 2; m_eidx = m_idx;
        end
      end
    end
  end

  // ---------------- engine responder ----------------
  bit         rnd_mode = 0, never_done = 0, b_inflight = 0, b_seen = 0;
  int         d_ack = 0, d_done = 20, nack_left = 0, b_aw = 0, b_cd = 0;
  logic [7:0] nack_byte = 8'h00, b_data = 8'h00;

  initial begin
    forever begin
      @(posedge clk_sda); #1;
      eng_ack = 0; eng_done = 0; eng_nack = 0;
      if (!busy) begin b_inflight = 0; b_seen = 0; end
      if (b_inflight) begin
        b_cd--;
        if (b_cd == 0) begin
          eng_done = 1; b_inflight = 0;
          if (nack_left > 0 && b_data == nack_byte) begin eng_nack = 1; nack_left--; end
          else if (rnd_mode) eng_nack = ($urandom_range(0, 4) == 0);
        end
      end else if (eng_req) begin
        if (!b_seen) begin b_seen = 1; b_aw = rnd_mode ? int'($urandom_range(0, 3)) : d_ack; end
        if (b_aw == 0) begin
          eng_ack = 1; b_seen = 0; b_inflight = 1; b_data = eng_data;
          if (never_done) b_cd = 1000000;
          else if (rnd_mode) b_cd = ($urandom_range(0, 49) == 0) ? 300 : int'($urandom_range(1, 40));
          else b_cd = d_done;
        end else begin
          b_aw--;
          eng_done = ($urandom_range(0, 7) == 0);
        end
      end else begin
        eng_ack  = ($urandom_range(0, 3) == 0);
        eng_done = ($urandom_range(0, 7) == 0);
        eng_nack = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic [15:0] wr_at(input int i);
    if (i < q_wr.size()) return q_wr[i];
    return 16'hDEAD;
  endfunction

  task automatic run_seq(input logic [7:0] cmd, output int s);
    @(posedge clk_sda); #1;
    start = 1; otp_cmd = cmd; s = cyc;
    @(posedge clk_sda); #1;
    start = 0;
  endtask

  task automatic wait_end(input int budget);
    int  n0;
    bit  ok;
    n0 = n_pulse; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sda); #1;
      if (n_pulse != n0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL wait_end: no done/error within %0d cycles", budget);
    end
  endtask

  logic [15:0] NOM [0:6] = '{16'h0550, 16'h0548, 16'h0553, 16'h0547, 16'h054E, 16'h0558, 16'h0411};

  initial begin
    int s, d0, seen;
    repeat (3) @(posedge clk_sda);
    #1 rst_n = 1;
    repeat (2) @(posedge clk_sda);

    // nominal: ack same cycle, done 20 cycles after ack -> 31-cycle write period
    q_wr.delete(); d0 = n_done;
    run_seq(8'h11, s); wait_end(600);
    chk("nom_done_time", done_cyc - s, 208);
    chk("nom_n_writes", q_wr.size(), 7);
    for (int i = 0; i < 7; i++) chk("nom_write", wr_at(i), NOM[i]);
    chk("nom_one_done", n_done - d0, 1);
    chk("nom_err_code", err_code, 0);

    // single NACK on byte 53, resent after a gap
    q_wr.delete(); nack_byte = 8'h53; nack_left = 1;
    run_seq(8'h11, s); wait_end(600);
    chk("nack1_done_time", done_cyc - s, 239);
    chk("nack1_n_writes", q_wr.size(), 8);
    chk("nack1_resend", wr_at(3), 16'h0553);
    chk("nack1_last", wr_at(7), 16'h0411);

    // retries exhausted on index 2
    q_wr.delete(); nack_left = 3;
    run_seq(8'h11, s); wait_end(600);
    chk("nack3_err_time", err_cyc - s, 146);
    chk("nack3_code", err_code, 1);
    chk("nack3_index", err_index, 2);
    chk("nack3_n_writes", q_wr.size(), 5);
    nack_left = 0;

    // timeout: handshake edge closes cycle hs, error pulse 255 cycles later
    q_wr.delete(); never_done = 1;
    run_seq(8'h11, s); wait_end(600);
    chk("tmo_delay", err_cyc - hs_cyc, 256);
    chk("tmo_code", err_code, 2);
    chk("tmo_index", err_index, 0);
    chk("tmo_n_writes", q_wr.size(), 1);
    never_done = 0;
    repeat (5) @(posedge clk_sda);
    #1 chk("tmo_code_held", err_code, 2);

    // completion on the final allowed wait cycle wins over expiry
    q_wr.delete(); d_done = 255;
    run_seq(8'h11, s); wait_end(2500);
    chk("edge_done_time", done_cyc - s, 1853);
    chk("edge_code", err_code, 0);
    d_done = 20;

    // ack stalled 5 cycles, start pulses while busy ignored
    q_wr.delete(); d_ack = 5;
    run_seq(8'h11, s);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_sda); #1;
      start = (i % 7 == 0); otp_cmd = 8'h00;
    end
    start = 0;
    wait_end(600);
    chk("stall_done_time", done_cyc - s, 243);
    chk("stall_last", wr_at(6), 16'h0411);
    d_ack = 0;

    // reset while waiting on index 4
    q_wr.delete();
    run_seq(8'h11, s);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_sda); #1;
      if (q_wr.size() == 5) break;
    end
    chk("rst_reach_idx4", q_wr.size(), 5);
    repeat (3) @(posedge clk_sda);
    #1 rst_n = 0;
    #1;
    chk("rst_now_busy", busy, 0);   chk("rst_now_req", eng_req, 0);
    chk("rst_now_done", done, 0);   chk("rst_now_err", error, 0);
    repeat (2) @(posedge clk_sda);
    #1 rst_n = 1;
    q_wr.delete(); d0 = n_done;
    run_seq(8'h01, s); wait_end(600);
    chk("rst_first", wr_at(0), 16'h0550);
    chk("rst_last", wr_at(6), 16'h0401);
    chk("rst_done_cnt", n_done - d0, 1);

    // out-of-set command
    q_wr.delete();
    run_seq(8'h22, s); wait_end(600);
`ifdef OTP_CMD_CHECK_EN
    chk("ill_err_time", err_cyc - s, 1);
    chk("ill_code", err_code, 3);
    chk("ill_index", err_index, 6);
    chk("ill_n_writes", q_wr.size(), 0);
`else
    chk("fwd_n_writes", q_wr.size(), 7);
    chk("fwd_last", wr_at(6), 16'h0422);
`endif

    // randomized traffic
    rnd_mode = 1; seen = n_pulse; d0 = n_pulse;
    for (int i = 0; i < 9000; i++) begin
      @(posedge clk_sda); #1;
      start = (n_pulse != seen) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      seen = n_pulse;
      case ($urandom_range(0, 3))
        0: otp_cmd = 8'h00;
        1: otp_cmd = 8'h11;
        2: otp_cmd = 8'h01;
        default: otp_cmd = 8'($urandom);
      endcase
    end
    start = 0;
    chk("rnd_progress", (n_pulse - d0) > 5, 1);
    repeat (5) @(posedge clk_sda);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
